// File: rtl/multicycle_control_unit.sv
// Moore-style multi-cycle RV32I controller: sequences fetch/decode/execute/writeback over 3-5 cycles
// for a datapath with one shared ALU and one unified memory port, with a sticky illegal trap.
module multicycle_control_unit #(
   parameter int unsigned INSTR_WIDTH    = 32,
   parameter int unsigned ALU_CTRL_WIDTH = 4,
   parameter bit          MEM_WAIT_EN    = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [INSTR_WIDTH-1:0]    instr_i,
   input  logic                      zero_i,
   input  logic                      lt_i,
   input  logic                      ltu_i,
   input  logic                      mem_ready_i,
   output logic                      PCWrite_o,
   output logic                      AdrSrc_o,
   output logic                      MemWrite_o,
   output logic                      IRWrite_o,
   output logic [1:0]                ResultSrc_o,
   output logic [1:0]                ALUSrcA_o,
   output logic [1:0]                ALUSrcB_o,
   output logic [ALU_CTRL_WIDTH-1:0] ALUControl_o,
   output logic [2:0]                ImmSrc_o,
   output logic                      RegWrite_o,
   output logic                      instr_done_o,
   output logic                      illegal_o
);

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpI     = 7'b0010011;
   localparam logic [6:0] OpBr    = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpJalr  = 7'b1100111;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111;

   localparam logic [ALU_CTRL_WIDTH-1:0] AluAdd   = ALU_CTRL_WIDTH'(0);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluSub   = ALU_CTRL_WIDTH'(1);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluAnd   = ALU_CTRL_WIDTH'(2);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluOr    = ALU_CTRL_WIDTH'(3);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluXor   = ALU_CTRL_WIDTH'(4);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluSlt   = ALU_CTRL_WIDTH'(5);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluSltu  = ALU_CTRL_WIDTH'(6);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluSll   = ALU_CTRL_WIDTH'(7);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluSrl   = ALU_CTRL_WIDTH'(8);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluSra   = ALU_CTRL_WIDTH'(9);
   localparam logic [ALU_CTRL_WIDTH-1:0] AluPassB = ALU_CTRL_WIDTH'(10);

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
      StAluWb, StBranch, StJal, StJalr1, StJalr2, StLui, StAuipc, StTrap
   } state_e;

   state_e state_q, state_d;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       ready, is_load, r_illegal, mem_illegal, br_illegal, br_taken, alt;
   logic [ALU_CTRL_WIDTH-1:0] alu_func;
   logic       unused_bits;

   assign opcode      = instr_i[6:0];
   assign funct3      = instr_i[14:12];
   assign funct7      = instr_i[31:25];
   assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

   // With waits disabled the memory is assumed to answer in the same cycle.
   assign ready   = MEM_WAIT_EN ? mem_ready_i : 1'b1;
   assign is_load = (opcode == OpLoad);
   // funct7[5] picks sub only for R-type; srai/sra use it in both formats.
   assign alt     = (opcode == OpR) && funct7[5];

   assign r_illegal = !((funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
   assign mem_illegal = is_load ? (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                                : (funct3[2] || (funct3 == 3'b011));

   always_comb begin
      br_taken   = 1'b0;
      br_illegal = 1'b0;
      unique case (funct3)
         3'b000:  br_taken = zero_i;
         3'b001:  br_taken = !zero_i;
         3'b100:  br_taken = lt_i;
         3'b101:  br_taken = !lt_i;
         3'b110:  br_taken = ltu_i;
         3'b111:  br_taken = !ltu_i;
         default: br_illegal = 1'b1;
      endcase
   end

   always_comb begin
      alu_func = AluAdd;
      unique case (funct3)
         3'b000: alu_func = alt ? AluSub : AluAdd;
         3'b001: alu_func = AluSll;
         3'b010: alu_func = AluSlt;
         3'b011: alu_func = AluSltu;
         3'b100: alu_func = AluXor;
         3'b101: alu_func = funct7[5] ? AluSra : AluSrl;
         3'b110: alu_func = AluOr;
         3'b111: alu_func = AluAnd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StFetch;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:    state_d = ready ? StDecode : StFetch;
         StDecode: begin
            case (opcode)
               OpLoad, OpStore: state_d = StMemAdr;
               OpR:             state_d = StExecR;
               OpI:             state_d = StExecI;
               OpBr:            state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr1;
               OpLui:           state_d = StLui;
               OpAuipc:         state_d = StAuipc;
               default:         state_d = StTrap;
            endcase
         end
         StMemAdr:   state_d = mem_illegal ? StTrap : (is_load ? StMemRead : StMemWrite);
         StMemRead:  state_d = ready ? StMemWb : StMemRead;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = ready ? StFetch : StMemWrite;
         StExecR:    state_d = r_illegal ? StTrap : StAluWb;
         StExecI:    state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StBranch:   state_d = br_illegal ? StTrap : StFetch;
         StJal:      state_d = StAluWb;
         StJalr1:    state_d = StJalr2;
         StJalr2:    state_d = StAluWb;
         StLui:      state_d = StAluWb;
         StAuipc:    state_d = StAluWb;
         StTrap:     state_d = StTrap;
         default:    state_d = StFetch;
      endcase
   end

   always_comb begin
      PCWrite_o    = 1'b0;
      AdrSrc_o     = 1'b0;
      MemWrite_o   = 1'b0;
      IRWrite_o    = 1'b0;
      ResultSrc_o  = 2'b00;
      ALUSrcA_o    = 2'b00;
      ALUSrcB_o    = 2'b00;
      ALUControl_o = AluAdd;
      RegWrite_o   = 1'b0;
      instr_done_o = 1'b0;
      illegal_o    = 1'b0;
      unique case (state_q)
         StFetch: begin
            ALUSrcB_o   = 2'b10;
            ResultSrc_o = 2'b10;
            IRWrite_o   = ready;
            PCWrite_o   = ready;
         end
         StDecode: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b01;
         end
         StMemAdr: begin
            ALUSrcA_o = 2'b10;
            ALUSrcB_o = 2'b01;
         end
         StMemRead:  AdrSrc_o = 1'b1;
         StMemWb: begin
            ResultSrc_o  = 2'b01;
            RegWrite_o   = 1'b1;
            instr_done_o = 1'b1;
         end
         StMemWrite: begin
            AdrSrc_o     = 1'b1;
            MemWrite_o   = 1'b1;
            instr_done_o = ready;
         end
         StExecR: begin
            ALUSrcA_o    = 2'b10;
            ALUControl_o = alu_func;
         end
         StExecI: begin
            ALUSrcA_o    = 2'b10;
            ALUSrcB_o    = 2'b01;
            ALUControl_o = alu_func;
         end
         StAluWb: begin
            RegWrite_o   = 1'b1;
            instr_done_o = 1'b1;
         end
         StBranch: begin
            ALUSrcA_o    = 2'b10;
            ALUControl_o = AluSub;
            PCWrite_o    = br_taken && !br_illegal;
            instr_done_o = !br_illegal;
         end
         StJal: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b10;
            PCWrite_o = 1'b1;
         end
         StJalr1: begin
            ALUSrcA_o = 2'b10;
            ALUSrcB_o = 2'b01;
         end
         StJalr2: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b10;
            PCWrite_o = 1'b1;
         end
         StLui: begin
            ALUSrcB_o    = 2'b01;
            ALUControl_o = AluPassB;
         end
         StAuipc: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b01;
         end
         StTrap:     illegal_o = 1'b1;
         default:    ;
      endcase
      // An instruction interrupted by reset must not commit anything.
      if (rst) begin
         PCWrite_o    = 1'b0;
         IRWrite_o    = 1'b0;
         MemWrite_o   = 1'b0;
         RegWrite_o   = 1'b0;
         instr_done_o = 1'b0;
      end
   end

   always_comb begin
      unique case (opcode)
         OpStore:        ImmSrc_o = 3'b001;
         OpBr:           ImmSrc_o = 3'b010;
         OpJal:          ImmSrc_o = 3'b011;
         OpLui, OpAuipc: ImmSrc_o = 3'b100;
         default:        ImmSrc_o = 3'b000;
      endcase
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation RV32I control unit for the multi-cycle CPU datapath, replacing the single-cycle combinational controller.
- A Moore FSM sequences each instruction over 3-5 cycles using a shared ALU and a unified memory port.
- Supports the full branch set, JAL/JALR, LUI/AUIPC, a memory ready handshake and a sticky illegal-instruction trap.
- Sits between the instruction register (IR) and the datapath muxes and enables.

Parameters:
INSTR_WIDTH, 32, instruction width; only 32 is legal.
ALU_CTRL_WIDTH, 4, width of ALUControl_o.
MEM_WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE stall on mem_ready_i; 0 = mem_ready_i ignored and treated as 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
instr_i  input  INSTR_WIDTH  IR contents; stable from DECODE until the next FETCH.
zero_i  input  1  ALU result == 0.
lt_i  input  1  signed rs1 < rs2 (from ALU subtract).
ltu_i  input  1  unsigned rs1 < rs2.
mem_ready_i  input  1  memory access completes this cycle.
PCWrite_o  output  1  PC load enable.
AdrSrc_o  output  1  memory address select: 0 = PC, 1 = Result.
MemWrite_o  output  1  data memory write enable.
IRWrite_o  output  1  IR and OldPC load enable.
ResultSrc_o  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
ALUSrcA_o  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
ALUSrcB_o  output  2  ALU B select: 00 = RD2, 01 = Imm, 10 = constant 4.
ALUControl_o  output  ALU_CTRL_WIDTH  ALU op (encoding below).
ImmSrc_o  output  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
RegWrite_o  output  1  register file write enable.
instr_done_o  output  1  one-cycle pulse in the final cycle of each instruction.
illegal_o  output  1  sticky trap flag.

Behaviour:
- Reset:
  - rst sampled high sets state to FETCH and clears illegal_o at the next edge.
  - While rst is high, PCWrite/IRWrite/MemWrite/RegWrite are forced to 0 combinationally.
  - Reset taken mid-instruction (including MEMWRITE wait) abandons the instruction; no partial writes after rst is seen.
- Output timing:
  - All outputs are Moore (decoded from state); exceptions are ImmSrc_o (decoded from opcode in every state) and the handshake-qualified enables below.
  - Unlisted enables are 0; unlisted selects are 00.
- ALUControl encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
  - R-type: funct3 decode; funct7[5] selects sub/sra.
  - I-ALU: funct7[5] honoured only for srai.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite assert only in the cycle mem_ready_i=1; that cycle moves to DECODE, otherwise FETCH holds.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut = OldPC+imm). Next state by opcode:
    - 0000011, 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR1
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - other -> TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Load -> MEMREAD, store -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready_i, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite held high until mem_ready_i. -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, R op. -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, I op. -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = taken. -> FETCH.
    - funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
    - funct3 010/011 -> TRAP.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite. -> ALUWB.
  - JALR1: ALUSrcA=10, ALUSrcB=01, add. -> JALR2.
  - JALR2: ResultSrc=00, PCWrite, ALUSrcA=01, ALUSrcB=10, add. -> ALUWB.
  - LUI: ALUSrcB=01, passB. -> ALUWB.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, add. -> ALUWB.
  - TRAP: all enables 0, illegal_o=1. Stays in TRAP until rst.
- Illegal funct combos also -> TRAP, from the EXEC/BRANCH decision point, with no RegWrite or PCWrite.
  - Illegal: R-type funct7 not in {0x00, 0x20}; 0x20 with funct3 not in {000, 101}.
  - Illegal: load/store funct3 not in {000, 001, 010, 100, 101} / {000, 001, 010}.
- instr_done_o asserts in MEMWB, MEMWRITE (ready cycle), ALUWB and BRANCH.
- Cycle counts with no wait: R/I/LUI/AUIPC/JAL/sw 4, lw 5, branch 3, jalr 5. Each mem_ready_i=0 cycle adds 1.

Test Plan:
- Reset: rst=1 for 2 cycles -> state FETCH, illegal_o=0, all enables 0 during rst.
- add 0x002081B3 and sub 0x402081B3, mem_ready_i=1 -> 4 cycles; ALUControl 0000/0001 in EXECR; RegWrite only in cycle 4; instr_done_o pulses once.
- lw 0x0000A183, mem_ready_i low 2 cycles in MEMREAD -> 7 cycles; AdrSrc=1 throughout the stall; RegWrite with ResultSrc=01 in the last cycle.
- Branches: beq 0x00208463 zero_i=1 -> PCWrite=1 in BRANCH; bne 0x00209463 zero_i=1 -> PCWrite=0. Both take 3 cycles.
- Trap: instr 0xFFFFFFFF -> TRAP after DECODE, illegal_o=1 for 10+ cycles with no enables; rst returns to FETCH with illegal_o=0.
- sw 0x0020A023, rst asserted on the second MEMWRITE wait cycle -> MemWrite forced 0 that cycle, FETCH next edge.
